// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter that sequences accesses onto one single-port RAM.
// Grants are one-cycle pulses; read data is returned with a one-cycle valid pulse.
module ram_port_arbiter #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state_q;
    logic          last_q;
    logic          gnt0_q, gnt1_q;
    logic          rvalid0_q, rvalid1_q;
    logic          ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_din_q;

    // Port 1 wins when it is the only requester, or when both request and port 0 went last.
    logic          win1_d;
    logic          we_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] din_d;

    assign win1_d = req1 & (~req0 | ~last_q);
    assign we_d   = win1_d ? we1    : we0;
    assign addr_d = win1_d ? addr1  : addr0;
    assign din_d  = win1_d ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid0_q <= 1'b0;
                    rvalid1_q <= 1'b0;
                    ram_we_q  <= 1'b0;
                    if (req0 | req1) begin
                        ram_addr_q <= addr_d;
                        ram_din_q  <= din_d;
                        ram_we_q   <= we_d;
                        gnt0_q     <= ~win1_d;
                        gnt1_q     <= win1_d;
                        last_q     <= win1_d;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The RAM performs the access at this edge; last_q names its owner.
                    gnt0_q    <= 1'b0;
                    gnt1_q    <= 1'b0;
                    ram_we_q  <= 1'b0;
                    rvalid0_q <= ~ram_we_q & ~last_q;
                    rvalid1_q <= ~ram_we_q & last_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign rdata0   = ram_dout;
    assign rdata1   = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: an event-scheduled model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [5:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [7:0] rdata0, rdata1, ram_din;
    logic [5:0] ram_addr;
    logic [7:0] ram_dout;

    ram_port_arbiter #(.DW(8), .AW(6)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous-read 64x8 RAM.
    logic [7:0] ram_mem [64];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access is accepted at any edge not earlier than free_edge; a read
    // completes one edge after acceptance with the memory contents at that point.
    int         edge_n = 0;
    int         free_edge = 0;
    int         rd_due = -1;
    int         rd_port = 0;
    int         m_last = 1;
    logic [5:0] rd_addr = '0;
    logic [7:0] mem_m [64];
    logic       e_g0 = 0, e_g1 = 0, e_rv0 = 0, e_rv1 = 0, e_we = 0;
    logic [5:0] e_addr = '0;
    logic [7:0] e_din = '0, e_rdata = '0;
    bit         m_ok = 0;

    always @(posedge clk) begin
        int w;
        edge_n++;
        e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_we = 0;
        if (rst) begin
            e_addr = '0; e_din = '0; m_last = 1;
            free_edge = edge_n + 1; rd_due = -1;
        end else begin
            if (rd_due == edge_n) begin
                if (rd_port == 0) e_rv0 = 1; else e_rv1 = 1;
                e_rdata = mem_m[rd_addr];
                rd_due = -1;
            end
            if (edge_n >= free_edge && (req0 || req1)) begin
                if (req0 && req1) w = (m_last == 0) ? 1 : 0;
                else w = req1 ? 1 : 0;
                if (w == 0) begin
                    e_g0 = 1; e_we = we0; e_addr = addr0; e_din = wdata0;
                end else begin
                    e_g1 = 1; e_we = we1; e_addr = addr1; e_din = wdata1;
                end
                if (e_we) mem_m[e_addr] = e_din;
                else begin rd_due = edge_n + 1; rd_port = w; rd_addr = e_addr; end
                free_edge = edge_n + 2;
                m_last = w;
            end
        end
        m_ok = 1;
    end

    int gnt_cnt0 = 0, gnt_cnt1 = 0, rv_cnt1 = 0;
    bit log_en = 0;
    int gq[$];

    always @(negedge clk) begin
        if (m_ok) begin
            chk("gnt0", gnt0, e_g0);
            chk("gnt1", gnt1, e_g1);
            chk("rvalid0", rvalid0, e_rv0);
            chk("rvalid1", rvalid1, e_rv1);
            chk("ram_we", ram_we, e_we);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_din", ram_din, e_din);
            if (e_rv0) chk("rdata0", rdata0, e_rdata);
            if (e_rv1) chk("rdata1", rdata1, e_rdata);
            chk("gnt_onehot", gnt0 & gnt1, 0);
            chk("rvalid_onehot", rvalid0 & rvalid1, 0);
        end
        if (gnt0) gnt_cnt0++;
        if (gnt1) gnt_cnt1++;
        if (rvalid1) rv_cnt1++;
        if (log_en && gnt0) gq.push_back(0);
        if (log_en && gnt1) gq.push_back(1);
    end

    task automatic drive(input int p, input logic r, input logic w, input logic [5:0] a, input logic [7:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the number of edges from request to grant; called at posedge+1.
    task automatic wait_gnt(input int p, output int waitc);
        bit seen = 0;
        waitc = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            waitc++;
            seen = (p == 0) ? gnt0 : gnt1;
        end
        if (!seen) chk("gnt_timeout", 0, 1);
    endtask

    task automatic access(input int p, input logic w, input logic [5:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int waitc);
        rd = '0;
        drive(p, 1'b1, w, a, d);
        wait_gnt(p, waitc);
        drive(p, 1'b0, w, a, d);
        if (waitc < 20 && !w) begin
            @(posedge clk); #1;
            chk("rvalid_after_gnt", (p == 0) ? rvalid0 : rvalid1, 1);
            rd = (p == 0) ? rdata0 : rdata1;
        end
        $display("port%0d %s addr=%0d data=%02h wait=%0d", p, w ? "WR" : "RD", a, w ? d : rd, waitc);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] rd0, rd1;
        int w0, w1, base;

        // 1. reset held with both requests high
        drive(0, 1'b1, 1'b1, 6'd5, 8'h55);
        drive(1, 1'b1, 1'b1, 6'd6, 8'h66);
        idle(2);
        chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
        chk("rst_ram_we", ram_we, 0); chk("rst_ram_addr", ram_addr, 0);
        drive(0, 1'b0, 1'b0, 6'd0, 8'h00);
        drive(1, 1'b0, 1'b0, 6'd0, 8'h00);
        rst = 1'b0;
        idle(1);

        // 2. port0 write then read of address 0
        access(0, 1'b1, 6'd0, 8'h10, rd0, w0);
        chk("t2_wr_latency", w0, 1);
        idle(1);
        access(0, 1'b0, 6'd0, 8'h00, rd0, w0);
        chk("t2_rd_latency", w0, 1);
        chk("t2_rdata", rd0, 8'h10);

        // 3. simultaneous writes right after reset: port0 first, port1 two edges later
        do_reset(1);
        fork
            access(0, 1'b1, 6'd2, 8'h11, rd0, w0);
            access(1, 1'b1, 6'd7, 8'hAF, rd1, w1);
        join
        chk("t3_wait0", w0, 1);
        chk("t3_wait1", w1, 3);
        idle(1);
        access(0, 1'b0, 6'd2, 8'h00, rd0, w0);
        chk("t3_rd_addr2", rd0, 8'h11);
        idle(1);
        access(1, 1'b0, 6'd7, 8'h00, rd1, w1);
        chk("t3_rd_addr7", rd1, 8'hAF);
        idle(1);

        // 4. continuous contention: grants alternate, bounded wait
        log_en = 1;
        fork
            for (int i = 0; i < 4; i++) begin
                logic [7:0] r; int wc;
                access(0, 1'b0, 6'd0, 8'h00, r, wc);
                chk("t4_rd0", r, 8'h10);
                chk("t4_wait0_le4", wc <= 4, 1);
            end
            for (int i = 0; i < 4; i++) begin
                logic [7:0] r; int wc;
                access(1, 1'b0, 6'd7, 8'h00, r, wc);
                chk("t4_rd1", r, 8'hAF);
                chk("t4_wait1_le4", wc <= 4, 1);
            end
        join
        log_en = 0;
        chk("t4_grant_count", gq.size(), 8);
        for (int i = 1; i < gq.size(); i++) chk("t4_alternate", gq[i] != gq[i-1], 1);
        idle(2);

        // 5. reset during the ISSUE cycle of a port1 read
        drive(1, 1'b1, 1'b0, 6'd7, 8'h00);
        wait_gnt(1, w1);
        base = rv_cnt1;
        drive(1, 1'b0, 1'b0, 6'd7, 8'h00);
        rst = 1'b1;
        idle(1);
        chk("t5_gnt1", gnt1, 0);
        chk("t5_ram_we", ram_we, 0);
        chk("t5_ram_addr", ram_addr, 0);
        rst = 1'b0;
        idle(4);
        chk("t5_no_rvalid1", rv_cnt1 - base, 0);
        fork
            access(0, 1'b0, 6'd2, 8'h00, rd0, w0);
            access(1, 1'b0, 6'd7, 8'h00, rd1, w1);
        join
        chk("t5_port0_first", w0, 1);
        chk("t5_port1_second", w1, 3);
        chk("t5_rd0", rd0, 8'h11);
        chk("t5_rd1", rd1, 8'hAF);
        idle(2);

        // 6a. req1 held only through the ISSUE cycle: no extra grant
        base = gnt_cnt1;
        drive(1, 1'b1, 1'b0, 6'd2, 8'h00);
        wait_gnt(1, w1);
        idle(1);
        drive(1, 1'b0, 1'b0, 6'd2, 8'h00);
        idle(4);
        chk("t6_single_gnt1", gnt_cnt1 - base, 1);
        $display("port1 RD held-1 grants=%0d", gnt_cnt1 - base);

        // 6b. req1 still high in the following IDLE: exactly one extra grant
        base = gnt_cnt1;
        drive(1, 1'b1, 1'b0, 6'd2, 8'h00);
        wait_gnt(1, w1);
        idle(2);
        chk("t6_regrant_seen", gnt1, 1);
        drive(1, 1'b0, 1'b0, 6'd2, 8'h00);
        idle(4);
        chk("t6_one_extra_gnt1", gnt_cnt1 - base, 2);
        $display("port1 RD held-2 grants=%0d", gnt_cnt1 - base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
